data_memory_ctrl: RTL and testbench

- Parametrised, handshaked successor to the single-cycle data memory.
- Adds byte/halfword/word loads and stores with sign/zero extension, and misalignment detection.
- Request/response interface with configurable access latency.
- Sits between the core's MEM stage and on-chip SRAM.
- Supports a multi-cycle core or a stall-capable pipeline.

---
 rtl/data_memory_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - handshaked byte/half/word data memory with fixed access latency
// Optional DMEM_PERF_CNT_EN adds load/store/error access counters.
module data_memory_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_err_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    logic [31:0]       mem_q [2**ADDR_W];

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              req_ready_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              access;
    logic              a_we;
    logic [2:0]        a_size;
    logic [ADDR_W+1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [1:0]        a_off;
    logic [ADDR_W-1:0] word_idx;
    logic              a_err;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_data;
    logic [31:0]       rsp_data;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && req_ready_q;
    assign access = (LATENCY == 1) ? accept : ((state_q == BUSY) && (cnt_q == 4'd0));

    // With single-cycle latency the access happens at the acceptance edge, so use the live request
    assign a_we     = (LATENCY == 1) ? req_we                    : we_q;
    assign a_size   = (LATENCY == 1) ? req_size                  : size_q;
    assign a_addr   = (LATENCY == 1) ? req_addr[ADDR_W+1:0]      : addr_q;
    assign a_wdata  = (LATENCY == 1) ? req_wdata                 : wdata_q;
    assign a_off    = a_addr[1:0];
    assign word_idx = a_addr[ADDR_W+1:2];

    always_comb begin
        a_err = 1'b0;
        case (a_size)
            3'b000, 3'b100: a_err = 1'b0;
            3'b001, 3'b101: a_err = a_off[0];
            3'b010:         a_err = (a_off != 2'b00);
            default:        a_err = 1'b1;
        endcase
    end

    assign rd_word   = mem_q[word_idx];
    assign rd_shift  = rd_word >> {a_off, 3'b000};
    assign lane_byte = rd_shift[7:0];
    assign lane_half = a_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (a_size)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'd0, lane_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    assign rsp_data = (a_we || a_err) ? 32'd0 : load_data;

    // Store data is replicated across lanes; the byte enables pick the lanes that change
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = a_wdata;
        case (a_size[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << a_off;
                wr_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = a_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{a_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = a_wdata;
            end
        endcase
    end

    // Memory has no reset; rst_n gating keeps a store from landing while reset is asserted
    always_ff @(posedge clk) begin
        if (access && rst_n && a_we && !a_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_rd_q;
    logic [31:0] perf_wr_q;
    logic [31:0] perf_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q  <= 32'd0;
            perf_wr_q  <= 32'd0;
            perf_err_q <= 32'd0;
        end else if (access) begin
            if (a_err) begin
                perf_err_q <= perf_err_q + 32'd1;
            end else if (a_we) begin
                perf_wr_q <= perf_wr_q + 32'd1;
            end else begin
                perf_rd_q <= perf_rd_q + 32'd1;
            end
        end
    end

    assign perf_rd_cnt  = perf_rd_q;
    assign perf_wr_cnt  = perf_wr_q;
    assign perf_err_cnt = perf_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_data;
                rsp_err_q   <= a_err;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        if (LATENCY != 1) begin
                            state_q     <= BUSY;
                            cnt_q       <= CNT_INIT;
                            req_ready_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl at LATENCY 2 and 1
// Honours DMEM_PERF_CNT_EN when defined.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] prd0, pwr0, per0, prd1, pwr1, per1;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] ref_mem [2][4096];
    int exp_rd [2];
    int exp_wr [2];
    int exp_er [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
`ifdef DMEM_PERF_CNT_EN
        , .perf_rd_cnt(prd0), .perf_wr_cnt(pwr0), .perf_err_cnt(per0)
`endif
    );

    data_memory_ctrl #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
`ifdef DMEM_PERF_CNT_EN
        , .perf_rd_cnt(prd1), .perf_wr_cnt(pwr1), .perf_err_cnt(per1)
`endif
    );

    function automatic logic f_rdy(input int s);
        return (s != 0) ? rdy1 : rdy0;
    endfunction
    function automatic logic f_rv(input int s);
        return (s != 0) ? rv1 : rv0;
    endfunction
    function automatic logic [31:0] f_rd(input int s);
        return (s != 0) ? rd1 : rd0;
    endfunction
    function automatic logic f_er(input int s);
        return (s != 0) ? er1 : er0;
    endfunction

    task automatic set_v(input int s, input logic val);
        if (s != 0) v1 = val;
        else        v0 = val;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-array memory model: width from size, errors from alignment, extension from size[2]
    task automatic model(input int s, input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int nb;
        int a;
        logic [31:0] v;
        nb    = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
        a     = int'(addr % 4096);
        err   = (size == 3'd3) || (size == 3'd6) || (size == 3'd7) || ((a % nb) != 0);
        rdata = 32'd0;
        if (err) begin
            exp_er[s]++;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[s][a + i] = 8'(wdata >> (8 * i));
            exp_wr[s]++;
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[s][a + i]) << (8 * i));
            if (!size[2] && nb == 1 && v >= 32'h80)   v = v - 32'h100;
            if (!size[2] && nb == 2 && v >= 32'h8000) v = v - 32'h10000;
            rdata = v;
            exp_rd[s]++;
        end
    endtask

    task automatic do_req(input int s, input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic [31:0] erd;
        logic ee;
        int n, k;
        model(s, we, size, addr, wdata, erd, ee);
        req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        set_v(s, 1'b1);
        n = 0;
        while (!f_rdy(s) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_bound", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        set_v(s, 1'b0);
        k = 1;
        while (!f_rv(s) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), (s != 0) ? 32'd1 : 32'd2);
        check("rdata", f_rd(s), erd);
        check("err", 32'(f_er(s)), 32'(ee));
        @(posedge clk); #1;
        check("rsp_pulse", 32'(f_rv(s)), 32'd0);
    endtask

    task automatic b2b(input int s);
        logic [31:0] eq_d[$];
        logic        eq_e[$];
        int          acc[$];
        int          rsp[$];
        int          lat;
        lat = (s != 0) ? 1 : 2;
        fork
            begin
                logic r;
                logic [31:0] erd;
                logic ee;
                for (int i = 0; i < 4; i++) begin
                    case (i)
                        0:       begin req_we = 1; req_size = 3'b010; req_addr = 32'h40; req_wdata = $urandom; end
                        1:       begin req_we = 0; req_size = 3'b010; req_addr = 32'h40; end
                        2:       begin req_we = 1; req_size = 3'b000; req_addr = 32'h41; req_wdata = $urandom; end
                        default: begin req_we = 0; req_size = 3'b001; req_addr = 32'h42; end
                    endcase
                    set_v(s, 1'b1);
                    for (int n = 0; n < 20; n++) begin
                        r = f_rdy(s);
                        @(posedge clk); #1;
                        if (r) begin
                            model(s, req_we, req_size, req_addr, req_wdata, erd, ee);
                            eq_d.push_back(erd);
                            eq_e.push_back(ee);
                            acc.push_back(cyc);
                            break;
                        end
                    end
                end
                set_v(s, 1'b0);
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    @(posedge clk); #2;
                    if (f_rv(s)) begin
                        rsp.push_back(cyc);
                        if (eq_d.size() > 0) begin
                            check("b2b_rdata", f_rd(s), eq_d.pop_front());
                            check("b2b_err", 32'(f_er(s)), 32'(eq_e.pop_front()));
                        end else begin
                            check("b2b_unexpected_rsp", 32'd1, 32'd0);
                        end
                    end
                end
            end
        join
        check("b2b_accepts", 32'(acc.size()), 32'd4);
        check("b2b_responses", 32'(rsp.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc.size() && i < rsp.size(); i++) begin
            check("b2b_rsp_delay", 32'(rsp[i] - acc[i]), 32'(lat - 1));
            if (i > 0) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(lat));
        end
    endtask

    task automatic rnd(input int s);
        logic [31:0] a;
        for (int i = 0; i < 16; i++) do_req(s, 1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            do_req(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
    endtask

    task automatic check_perf(input int s);
`ifdef DMEM_PERF_CNT_EN
        check("perf_rd", (s != 0) ? prd1 : prd0, 32'(exp_rd[s]));
        check("perf_wr", (s != 0) ? pwr1 : pwr0, 32'(exp_wr[s]));
        check("perf_err", (s != 0) ? per1 : per0, 32'(exp_er[s]));
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
        req_we = 1'b0; req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 0; exp_wr[s] = 0; exp_er[s] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", 32'(f_rdy(s)), 32'd1);
            check("reset_rsp_valid", 32'(f_rv(s)), 32'd0);
            check("reset_rdata", f_rd(s), 32'd0);
            check("reset_err", 32'(f_er(s)), 32'd0);
            check_perf(s);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        do_req(0, 1'b0, 3'b000, 32'h13, 32'h0);
        do_req(0, 1'b0, 3'b100, 32'h13, 32'h0);
        do_req(0, 1'b0, 3'b001, 32'h10, 32'h0);
        do_req(0, 1'b0, 3'b101, 32'h12, 32'h0);
        do_req(0, 1'b1, 3'b000, 32'h11, 32'h55);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        do_req(0, 1'b0, 3'b010, 32'h12, 32'h0);
        do_req(0, 1'b1, 3'b001, 32'h13, 32'h1234);
        do_req(0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        do_req(0, 1'b0, 3'b010, 32'hABCD_F010, 32'h0);

        do_req(0, 1'b1, 3'b010, 32'h20, 32'hCAFE0001);
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0);
        req_we = 1'b1; req_size = 3'b010; req_addr = 32'h20; req_wdata = 32'h1;
        v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 0; exp_wr[s] = 0; exp_er[s] = 0;
        end
        check("midrst_ready", 32'(rdy0), 32'd1);
        check("midrst_rsp_valid", 32'(rv0), 32'd0);
        check("midrst_rdata", rd0, 32'd0);
        check("midrst_err", 32'(er0), 32'd0);
        check_perf(0);
        check_perf(1);
        @(posedge clk); #1;
        check("midrst_no_rsp", 32'(rv0), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("postrst_no_rsp", 32'(rv0), 32'd0);
        end
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0);

        b2b(0);
        b2b(1);
        rnd(0);
        rnd(1);
        check_perf(0);
        check_perf(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
